// File: rtl/calc_pkg.sv
// Shared calculator definitions: result/operand widths, BCD digit count and
// the conversion FSM state encoding.
package calc_pkg;

    localparam int unsigned RESULT_W   = 54;
    localparam int unsigned OPERAND_W  = 27;
    localparam int unsigned BCD_DIGITS = 16;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

endpackage : calc_pkg

// File: rtl/bcd_add3.sv
// Double-dabble digit correction cell: adds 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next digit.
module bcd_add3 (
    input  logic [3:0] din_i,
    output logic [3:0] dout_o
);

    always_comb begin
        dout_o = (din_i >= 4'd5) ? (din_i + 4'd3) : din_i;
    end

endmodule : bcd_add3

// File: rtl/result_bcd.sv
// Signed calculator result to packed BCD converter (iterative double-dabble).
// Leading-zero blanking of digit_en is enabled by defining RESULT_BCD_ZERO_BLANK_EN.
module result_bcd
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH  = RESULT_W,
    parameter int unsigned DIGITS = BCD_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      data3,
    input  logic                  data_latch,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  sign,
    output logic                  ovf,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  valid,
    output logic                  busy
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [WIDTH-1:0]    mag_q;
    logic [BW-1:0]       work_q;
    logic                wovf_q;
    logic                wsign_q;
    logic [BW-1:0]       bcd_q;
    logic                sign_q;
    logic                ovf_q;
    logic [DIGITS-1:0]   en_q;
    logic                valid_q;
    logic                busy_q;

    logic [WIDTH-1:0]    mag_in;
    logic [BW-1:0]       adj;
    logic [BW+WIDTH:0]   sh;
    logic [BW-1:0]       work_d;
    logic [WIDTH-1:0]    mag_d;
    logic [DIGITS-1:0]   en_d;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din_i  (work_q[4*g +: 4]),
            .dout_o (adj[4*g +: 4])
        );
    end

    // Unsigned magnitude; the most negative input maps to 2^(WIDTH-1) without wrap.
    always_comb begin
        mag_in = data3[WIDTH-1] ? ('0 - data3) : data3;
    end

    always_comb begin
        sh     = {adj, mag_q, 1'b0};
        work_d = sh[BW+WIDTH-1:WIDTH];
        mag_d  = sh[WIDTH-1:0];
    end

`ifdef RESULT_BCD_ZERO_BLANK_EN
    always_comb begin
        logic any_nz;
        int unsigned i;
        any_nz = 1'b0;
        en_d   = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            i        = DIGITS - 1 - k;
            any_nz   = any_nz | (|work_d[4*i +: 4]);
            en_d[i]  = any_nz;
        end
        en_d[0] = 1'b1;
    end
`else
    always_comb begin
        en_d = '1;
    end
`endif

    // Outputs load on the final shift edge so they are already valid during DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mag_q   <= '0;
            work_q  <= '0;
            wovf_q  <= 1'b0;
            wsign_q <= 1'b0;
            bcd_q   <= '0;
            sign_q  <= 1'b0;
            ovf_q   <= 1'b0;
            en_q    <= DIGITS'(1);
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (data_latch) begin
                        wsign_q <= data3[WIDTH-1];
                        mag_q   <= mag_in;
                        work_q  <= '0;
                        wovf_q  <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    work_q <= work_d;
                    mag_q  <= mag_d;
                    cnt_q  <= cnt_q + CW'(1);
                    if (adj[BW-1]) begin
                        wovf_q <= 1'b1;
                    end
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        bcd_q   <= work_d;
                        sign_q  <= wsign_q;
                        ovf_q   <= wovf_q | adj[BW-1];
                        en_q    <= en_d;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bcd      = bcd_q;
        sign     = sign_q;
        ovf      = ovf_q;
        digit_en = en_q;
        valid    = valid_q;
        busy     = busy_q;
    end

endmodule : result_bcd

// File: tb/tb_result_bcd.sv
// Scoreboard bench for result_bcd: a 16-digit instance and a 4-digit instance
// for overflow boundaries; expected results are queued at issue time.
module tb_result_bcd;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [53:0] d_a, d_b;
    logic        la, lb;

    logic [63:0] bcd_a;
    logic        sign_a, ovf_a, valid_a, busy_a;
    logic [15:0] en_a;
    logic [15:0] bcd_b;
    logic        sign_b, ovf_b, valid_b, busy_b;
    logic [3:0]  en_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [63:0] bcd;
        logic        sign;
        logic        ovf;
        logic [15:0] en;
        bit          chk_bcd;
        int          due;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    result_bcd #(.WIDTH(54), .DIGITS(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .data3(d_a), .data_latch(la),
        .bcd(bcd_a), .sign(sign_a), .ovf(ovf_a), .digit_en(en_a),
        .valid(valid_a), .busy(busy_a)
    );

    result_bcd #(.WIDTH(54), .DIGITS(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .data3(d_b), .data_latch(lb),
        .bcd(bcd_b), .sign(sign_b), .ovf(ovf_b), .digit_en(en_b),
        .valid(valid_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare(input string tag, input exp_t e, input logic [63:0] b,
                           input logic s, input logic o, input logic [15:0] en);
        chk({tag, "_cycle"}, 64'(cyc), 64'(e.due));
        chk({tag, "_sign"}, 64'(s), 64'(e.sign));
        chk({tag, "_ovf"}, 64'(o), 64'(e.ovf));
        if (e.chk_bcd) begin
            chk({tag, "_bcd"}, b, e.bcd);
            chk({tag, "_digit_en"}, 64'(en), 64'(e.en));
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid_a) begin
                if (qa.size() == 0) begin
                    chk("unexpected_valid_a", 64'(1), 64'(0));
                end else begin
                    e = qa.pop_front();
                    compare("a", e, bcd_a, sign_a, ovf_a, en_a);
                end
            end
            if (valid_b) begin
                if (qb.size() == 0) begin
                    chk("unexpected_valid_b", 64'(1), 64'(0));
                end else begin
                    e = qb.pop_front();
                    compare("b", e, 64'(bcd_b), sign_b, ovf_b, 16'(en_b));
                end
            end
        end
    endtask

    task automatic issue(input bit use_b, input logic [53:0] d, input logic [63:0] b,
                         input logic s, input logic o, input logic [15:0] en_blank,
                         input bit chk_bcd);
        exp_t e;
        @(posedge clk);
        #1;
        e.bcd     = b;
        e.sign    = s;
        e.ovf     = o;
        e.chk_bcd = chk_bcd;
        e.due     = cyc + 55;
`ifdef RESULT_BCD_ZERO_BLANK_EN
        e.en      = en_blank;
`else
        e.en      = use_b ? 16'h000F : 16'hFFFF;
`endif
        if (use_b) begin
            d_b = d; lb = 1'b1; qb.push_back(e);
        end else begin
            d_a = d; la = 1'b1; qa.push_back(e);
        end
        @(posedge clk);
        #1;
        la = 1'b0;
        lb = 1'b0;
        chk("busy_after_capture", 64'(use_b ? busy_b : busy_a), 64'(1));
    endtask

    task automatic wait_valid(input bit use_b);
        int n = 0;
        while (!(use_b ? valid_b : valid_a) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("valid_timeout", 64'(0), 64'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_bcd"}, bcd_a, 64'h0);
        chk({tag, "_sign"}, 64'(sign_a), 64'(0));
        chk({tag, "_ovf"}, 64'(ovf_a), 64'(0));
        chk({tag, "_digit_en"}, 64'(en_a), 64'h0001);
        chk({tag, "_valid"}, 64'(valid_a), 64'(0));
        chk({tag, "_busy"}, 64'(busy_a), 64'(0));
        chk({tag, "_digit_en_b"}, 64'(en_b), 64'h1);
    endtask

    initial begin
        rst_n = 1'b0;
        la = 1'b0; lb = 1'b0;
        d_a = '0;  d_b = '0;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        issue(0, 54'd0, 64'h0, 1'b0, 1'b0, 16'h0001, 1);
        wait_valid(0);
        issue(0, 54'd12345, 64'h12345, 1'b0, 1'b0, 16'h001F, 1);
        wait_valid(0);
        issue(0, -54'sd1, 64'h1, 1'b1, 1'b0, 16'h0001, 1);
        wait_valid(0);
        issue(0, 54'h20_0000_0000_0000, 64'h9007_1992_5474_0992, 1'b1, 1'b0, 16'hFFFF, 1);
        wait_valid(0);
        issue(0, 54'h1F_FFFF_FFFF_FFFF, 64'h9007_1992_5474_0991, 1'b0, 1'b0, 16'hFFFF, 1);
        wait_valid(0);
        issue(0, -54'sd987654321, 64'h9_8765_4321, 1'b1, 1'b0, 16'h01FF, 1);
        wait_valid(0);

        // Second latch mid-conversion must be dropped.
        issue(0, 54'd100, 64'h100, 1'b0, 1'b0, 16'h0007, 1);
        repeat (8) @(posedge clk);
        #1;
        d_a = 54'd200; la = 1'b1;
        @(posedge clk);
        #1;
        la = 1'b0;
        wait_valid(0);
        issue(0, 54'd200, 64'h200, 1'b0, 1'b0, 16'h0007, 1);
        wait_valid(0);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_bcd", bcd_a, 64'h200);
        chk("hold_busy", 64'(busy_a), 64'(0));

        // Reset in the middle of a conversion aborts it without a strobe.
        @(posedge clk);
        #1;
        d_a = 54'd4321; la = 1'b1;
        @(posedge clk);
        #1;
        la = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(posedge clk);
        issue(0, 54'd4321, 64'h4321, 1'b0, 1'b0, 16'h000F, 1);
        wait_valid(0);

        issue(1, 54'd10000, 64'h0, 1'b0, 1'b1, 16'h000F, 0);
        wait_valid(1);
        issue(1, 54'd9999, 64'h9999, 1'b0, 1'b0, 16'h000F, 1);
        wait_valid(1);
        issue(1, -54'sd10000, 64'h0, 1'b1, 1'b1, 16'h000F, 0);
        wait_valid(1);
        issue(1, 54'd5, 64'h0005, 1'b0, 1'b0, 16'h0001, 1);
        wait_valid(1);

        repeat (5) @(posedge clk);
        chk("queue_a_empty", 64'(qa.size()), 64'(0));
        chk("queue_b_empty", 64'(qb.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_result_bcd
